// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_DEPTH    = 32;
    localparam int unsigned RF_NUM_READ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } rf_state_e;

    // Smallest r with 2**r >= n; used to size register indices.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: sweeps idx 0..DEPTH-1 one entry per cycle, then
// pulses clear-done for one cycle before returning to IDLE.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH  = RF_DEPTH,
    parameter int unsigned ADDR_W = clog2(RF_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr_req,
    output logic              o_busy,
    output logic              o_clr_done,
    output logic              o_clr_en_c,
    output logic [ADDR_W-1:0] o_clr_idx
);

    rf_state_e         r_state;
    rf_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic              r_busy;
    logic              r_clr_done;

    // State, index and the registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_clr_done <= (w_state_nxt == DONE);
        end
    end

    // Sweep ends on the last index rather than on counter wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        o_clr_en_c  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_clr_req) begin
                    w_state_nxt = CLEAR;
                    w_idx_nxt   = '0;
                end
            end
            CLEAR: begin
                o_clr_en_c = 1'b1;
                w_idx_nxt  = r_idx + ADDR_W'(1);
                if (r_idx == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_busy     = r_busy;
    assign o_clr_done = r_clr_done;
    assign o_clr_idx  = r_idx;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, single-write register file with a sequential bulk-clear engine.
// Optional same-cycle write-to-read forwarding under `REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned ADDR_W   = clog2(DEPTH),
    parameter int unsigned NUM_READ = RF_NUM_READ,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       regWrite,
    input  logic [ADDR_W-1:0]          writeReg,
    input  logic [DATA_W-1:0]          writeData,
    input  logic [NUM_READ*ADDR_W-1:0] readReg,
    output logic [NUM_READ*DATA_W-1:0] readData,
    input  logic                       clrReq,
    output logic                       busy,
    output logic                       clrDone
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_busy;
    logic              w_clr_en;
    logic [ADDR_W-1:0] w_clr_idx;
    logic              w_wr_zero;
    logic              w_wr_en;

    regfile_clear_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr_req  (clrReq),
        .o_busy     (w_busy),
        .o_clr_done (clrDone),
        .o_clr_en_c (w_clr_en),
        .o_clr_idx  (w_clr_idx)
    );

    // Writes only land in IDLE; index 0 is dropped when hardwired to zero.
    assign w_wr_zero = (ZERO_REG != 0) && (writeReg == '0);
    assign w_wr_en   = regWrite && !w_busy && !w_wr_zero;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clr_en) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_wr_en) begin
            r_mem[writeReg] <= writeData;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = readReg[k*ADDR_W +: ADDR_W];

        // Zero override is applied last so it wins over forwarding.
        always_comb begin
            w_rd = r_mem[w_ra];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_en && (w_ra == writeReg)) begin
                w_rd = writeData;
            end
`endif
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_rd = '0;
            end
        end

        assign readData[k*DATA_W +: DATA_W] = w_rd;
    end

    assign busy = w_busy;

endmodule
